// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - request/result bundle between operand muxes, iterative_alu and writeback
interface iterative_alu_if #(
   parameter int NBits = 32
);
   logic             Start;
   logic [3:0]       ALUOperation;
   logic [NBits-1:0] A;
   logic [NBits-1:0] B;
   logic [4:0]       Shamt;
   logic             Busy;
   logic             Done;
   logic [NBits-1:0] ALUResult;
   logic             Zero;
   logic             Invalid;

   modport master (
      output Start, ALUOperation, A, B, Shamt,
      input  Busy, Done, ALUResult, Zero, Invalid
   );

   modport slave (
      input  Start, ALUOperation, A, B, Shamt,
      output Busy, Done, ALUResult, Zero, Invalid
   );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - registered ALU with one-bit-per-cycle SLL/SRL and Start/Busy/Done handshake
module iterative_alu #(
   parameter int NBits = 32
) (
   input  logic          clk,
   input  logic          reset,
   iterative_alu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [3:0] OP_SLL = 4'b0000;
   localparam logic [3:0] OP_SRL = 4'b0001;
   localparam logic [3:0] OP_LUI = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_NOR = 4'b0111;
   localparam logic [3:0] OP_OR  = 4'b1000;

   state_t           state_q, state_d;
   logic [NBits-1:0] acc_q, acc_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [NBits-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             invalid_q, invalid_d;

   logic [NBits-1:0] alu_val;
   logic             alu_inv;
   logic [NBits-1:0] acc_shifted;
   logic             load;

   always_comb begin
      alu_val = '0;
      alu_inv = 1'b0;
      case (bus.ALUOperation)
         OP_LUI:  alu_val = {bus.B[15:0], {(NBits-16){1'b0}}};
         OP_ADD:  alu_val = bus.A + bus.B;
         OP_AND:  alu_val = bus.A & bus.B;
         OP_NOR:  alu_val = ~(bus.A | bus.B);
         OP_OR:   alu_val = bus.A | bus.B;
         default: alu_inv = 1'b1;
      endcase
   end

   // dir_q=1 selects a logical right shift (SRL), else left (SLL)
   assign acc_shifted = dir_q ? (acc_q >> 1) : (acc_q << 1);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      result_d  = result_q;
      invalid_d = invalid_q;
      load      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               if (bus.ALUOperation == OP_SLL || bus.ALUOperation == OP_SRL) begin
                  if (bus.Shamt == 5'd0) begin
                     result_d  = bus.B;
                     invalid_d = 1'b0;
                     load      = 1'b1;
                     state_d   = DONE;
                  end else begin
                     acc_d   = bus.B;
                     cnt_d   = bus.Shamt;
                     dir_d   = bus.ALUOperation[0];
                     state_d = SHIFT;
                  end
               end else begin
                  result_d  = alu_val;
                  invalid_d = alu_inv;
                  load      = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         SHIFT: begin
            acc_d = acc_shifted;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               result_d  = acc_shifted;
               invalid_d = 1'b0;
               load      = 1'b1;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      zero_d = load ? (result_d == '0) : zero_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         invalid_q <= invalid_d;
      end
   end

   assign bus.Busy      = (state_q != IDLE);
   assign bus.Done      = (state_q == DONE);
   assign bus.ALUResult = result_q;
   assign bus.Zero      = zero_q;
   assign bus.Invalid   = invalid_q;
endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Execution-side consumer of the 4-bit ALUOperation code produced by the ALU control decoder in the MIPS datapath.
- Executes the same operation encoding as a registered, handshaked unit.
- Shifts (SLL/SRL) are iterative, one bit per cycle, driven by the instruction's shamt field. All other operations complete in one cycle.
- Sits between the register-file/immediate operand muxes and the writeback mux. Multi-cycle control stalls on Busy.

Parameters:
- NBits, 32, operand and result width (must be >= 17 so the LUI packing is defined).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- Start  input  1  request strobe; accepted only in IDLE.
- ALUOperation  input  4  operation code, sampled with Start.
- A  input  NBits  operand A (rs), sampled with Start.
- B  input  NBits  operand B (rt or immediate), sampled with Start.
- Shamt  input  5  shift amount, sampled with Start.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; result valid.
- ALUResult  output  NBits  registered result; held until next Done.
- Zero  output  1  registered (ALUResult == 0), updated with ALUResult.
- Invalid  output  1  registered; high if the last completed op code was unsupported.

Behaviour:
- Encoding:
  - 0000 SLL: B<<Shamt.
  - 0001 SRL: B>>Shamt, logical.
  - 0010 LUI: {B[15:0], zeros}.
  - 0011 ADD: A+B, wraps modulo 2^NBits, no overflow flag.
  - 0101 AND: A&B.
  - 0111 NOR: ~(A|B).
  - 1000 OR: A|B.
  - Any other code (including 1001, the decoder default): result 0, Invalid=1.
- Reset (reset==0 at an edge): state=IDLE, Busy=0, Done=0, ALUResult=0, Zero=1, Invalid=0, shift accumulator and counter = 0.
  - Reset overrides Start in the same cycle.
  - Reset mid-shift aborts the operation; no Done is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE with Start=1 (the accept edge):
  - Non-shift op: compute result, load ALUResult/Zero/Invalid, go to DONE.
  - Shift op with Shamt==0: ALUResult=B, go to DONE.
  - Shift op with Shamt>0: accumulator=B, counter=Shamt, latch direction, go to SHIFT.
- SHIFT:
  - Each cycle, shift the accumulator by 1 in the latched direction (zero fill) and decrement the counter.
  - When the counter reaches 0, load ALUResult/Zero (Invalid=0) and go to DONE.
- DONE: Done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: Done is high in the cycle beginning k+1 edges after the accept edge.
  - k = Shamt for SLL/SRL.
  - k = 0 for all other ops.
- Start while Busy is ignored. Operands are not re-sampled. Caller must hold Start until it sees Busy.
- Back-to-back: Start in the IDLE cycle immediately after DONE is accepted. Minimum issue interval is 2 cycles.
- ALUResult/Zero/Invalid change only at the edge entering DONE (or on reset). They are stable from Done until the next completion.
- Shamt=31: 31 SHIFT cycles, Done on edge 32 after accept. The result keeps only the bit shifted to the far end.
- Input changes during SHIFT have no effect.

Test Plan:
- Reset: reset=0 for 2 cycles with Start=1 -> Busy=0, Done=0, ALUResult=0, Zero=1, Invalid=0.
- ADD: A=0xFFFFFFFF, B=0x00000001, op 0011 -> Done 1 cycle after accept, ALUResult=0, Zero=1. Then AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0, Zero=0.
- SLL/SRL:
  - op 0000, B=0x00000001, Shamt=4 -> Busy for 5 cycles, Done on edge 5 after accept, ALUResult=0x00000010.
  - op 0001, B=0x80000000, Shamt=31 -> 0x00000001 on edge 32.
  - Shamt=0 -> Done on edge 1, ALUResult=B.
- LUI/NOR/OR:
  - op 0010, B=0x00001234 -> 0x12340000.
  - op 0111, A=B=0 -> 0xFFFFFFFF.
  - op 1000, A=0x0F, B=0xF0 -> 0xFF.
- Invalid and busy-ignore:
  - op 1001 -> Done, ALUResult=0, Invalid=1.
  - Start with ADD pulsed during a Shamt=8 SLL -> ignored; only the SLL result appears.
  - Next valid op clears Invalid.
- Reset mid-shift: SLL Shamt=10, reset=0 at cycle 3 -> no Done, IDLE next cycle. A following ADD 2+3 completes normally with ALUResult=5.
